ind_driver: RTL and testbench
=============================

IND_DRIVER -- requirements
Module: ind_driver

Interface
REQ-001 SHALL have parameter IND_1, default 11, meaning the result input width.
REQ-002 SHALL have parameter CONTROL, default 3, meaning the control-code input width.
REQ-003 SHALL have parameter REFRESH_DIV, default 50000, meaning clk_IND cycles per digit scan slot; minimum 2.
REQ-004 SHALL have port clk_IND  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_IND  input  1  reset; synchronous and active-high.
REQ-006 SHALL have port ind_1  input  IND_1  unsigned result from the ALU stage.
REQ-007 SHALL have port control  input  CONTROL  ALU status code (0 plain, 1 minus, 2 divide-by-zero, 4 divide result ×100).
REQ-008 SHALL have port seg  output  8  active-low segments; seg[7]=dp, seg[6:0]=g..a.
REQ-009 SHALL have port an  output  4  active-low digit enables; an[0] is the rightmost digit.

Function
REQ-010 SHALL latch ind_1 and control into a shadow pair and start a conversion when the inputs differ from the shadow pair while FSM is in IDLE.
REQ-011 SHALL run FSM states IDLE -> LOAD (1 cycle) -> SHIFT (exactly IND_1 cycles) -> DONE (1 cycle) -> IDLE.
REQ-012 SHALL convert with double-dabble: each SHIFT cycle adds 3 to every BCD nibble >= 5, then shifts left by one bit.
REQ-013 SHALL produce 4 BCD digits; 11-bit inputs (max 2047) never overflow.
REQ-014 SHALL update all four display digit registers atomically in DONE; latency from input change to new glyphs is IND_1+3 cycles.
REQ-015 SHALL ignore input changes during LOAD/SHIFT/DONE; a changed input is re-detected in the IDLE cycle and converted again.
REQ-016 SHALL, for control=0, blank leading zeros on digits 3..1; digit 0 is always shown.
REQ-017 SHALL, for control=1, apply the control=0 rule and show a minus glyph (g only) on digit 3.
REQ-018 SHALL, for control=2, show "Err" on digits 3..1 and blank digit 0, ignoring ind_1.
REQ-019 SHALL, for control=4, show format XX.XX: dp lit on digit 2, digits 2..0 never blanked, digit 3 blanked if zero.
REQ-020 SHALL show "----" for any other control value.
REQ-021 SHALL count clk_IND cycles 0..REFRESH_DIV-1 and wrap; on wrap it advances the scan index 0->1->2->3->0.
REQ-022 SHALL drive exactly one an bit low, the one selected by the scan index, with seg showing that digit's glyph in the same cycle.
REQ-023 SHALL register seg and an so that both change on the same edge.

Reset
REQ-024 SHALL, while rst_IND=1, set seg=8'hFF, an=4'hF, FSM=IDLE, refresh counter=0, scan index=0, and all digit registers to blank.
REQ-025 SHALL abort any conversion in progress on reset without updating digits.
REQ-026 SHALL mark the shadow pair invalid on reset so the first IDLE cycle after reset always starts a conversion.

Structure
REQ-027 SHALL place control codes (CODE_P=0, CODE_M=1, CODE_D0=2, CODE_D=4), glyph constants (0-9, blank, minus, E, r, dash) and the FSM state encoding in shared package calc_pkg.
REQ-028 SHALL instantiate one sub-module bin2bcd holding the sequential double-dabble datapath and FSM, with start/done handshake to ind_driver.

Verification (REFRESH_DIV=4)
REQ-029 SHALL check: reset release with ind_1=0, control=0 -> after 14 cycles, digits "   0"; an cycles 1110,1101,1011,0111 every 4 clocks.
REQ-030 SHALL check: ind_1=225, control=0 -> digit glyphs " 225" exactly 14 cycles after the change.
REQ-031 SHALL check: ind_1=7, control=1 -> "-  7"; ind_1=150, control=4 -> " 1.50" with dp on digit 2; ind_1=1500, control=4 -> "15.00".
REQ-032 SHALL check: control=2 with any ind_1 -> "Err " and seg[7]=1 on all digits.
REQ-033 SHALL check: ind_1 changes 3 cycles into SHIFT -> old conversion completes, then re-conversion; final digits match the new value.
REQ-034 SHALL check: rst_IND asserted mid-SHIFT -> seg=8'hFF, an=4'hF next cycle; fresh conversion after release.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared constants for the calculator display path: ALU status codes,
// active-low 7-segment glyphs (bit 7 = dp, 1 = off) and the converter FSM encoding.
package calc_pkg;

  localparam int unsigned CODE_P  = 0;
  localparam int unsigned CODE_M  = 1;
  localparam int unsigned CODE_D0 = 2;
  localparam int unsigned CODE_D  = 4;

  localparam int unsigned BCD_DIGITS = 4;
  localparam int unsigned BCD_W      = 4 * BCD_DIGITS;

  localparam logic [7:0] GLYPH_0     = 8'hC0;
  localparam logic [7:0] GLYPH_1     = 8'hF9;
  localparam logic [7:0] GLYPH_2     = 8'hA4;
  localparam logic [7:0] GLYPH_3     = 8'hB0;
  localparam logic [7:0] GLYPH_4     = 8'h99;
  localparam logic [7:0] GLYPH_5     = 8'h92;
  localparam logic [7:0] GLYPH_6     = 8'h82;
  localparam logic [7:0] GLYPH_7     = 8'hF8;
  localparam logic [7:0] GLYPH_8     = 8'h80;
  localparam logic [7:0] GLYPH_9     = 8'h90;
  localparam logic [7:0] GLYPH_BLANK = 8'hFF;
  localparam logic [7:0] GLYPH_MINUS = 8'hBF;
  localparam logic [7:0] GLYPH_E     = 8'h86;
  localparam logic [7:0] GLYPH_R     = 8'hAF;
  localparam logic [7:0] GLYPH_DASH  = 8'hBF;
  localparam logic [7:0] DP_MASK     = 8'h7F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } conv_state_e;

  function automatic logic [7:0] digit_glyph(input logic [3:0] d);
    logic [7:0] g;
    case (d)
      4'd0:    g = GLYPH_0;
      4'd1:    g = GLYPH_1;
      4'd2:    g = GLYPH_2;
      4'd3:    g = GLYPH_3;
      4'd4:    g = GLYPH_4;
      4'd5:    g = GLYPH_5;
      4'd6:    g = GLYPH_6;
      4'd7:    g = GLYPH_7;
      4'd8:    g = GLYPH_8;
      4'd9:    g = GLYPH_9;
      default: g = GLYPH_DASH;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/bin2bcd.sv
// Sequential double-dabble converter: start pulse in IDLE, one LOAD cycle,
// BIN_W shift cycles, then one DONE cycle with the BCD result stable.
module bin2bcd
  import calc_pkg::*;
#(
  parameter int unsigned BIN_W = 11
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [BIN_W-1:0]   bin_i,
  output logic               idle_o,
  output logic               done_o,
  output logic [BCD_W-1:0]   bcd_o
);

  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  conv_state_e        state_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BIN_W-1:0]   bin_q;
  logic [CNT_W-1:0]   cnt_q;

  // Add-3 correction on every nibble that would reach 10 after the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          bcd_q   <= '0;
          bin_q   <= bin_i;
          cnt_q   <= '0;
          state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
          {bcd_q, bin_q} <= {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
          cnt_q          <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BIN_W - 1)) state_q <= ST_DONE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign idle_o = (state_q == ST_IDLE);
  assign done_o = (state_q == ST_DONE);
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/ind_driver.sv
// 4-digit multiplexed 7-segment driver for ALU results: change detection into a
// shadow pair, BCD conversion, status-dependent formatting and a round-robin digit scan.
module ind_driver
  import calc_pkg::*;
#(
  parameter int unsigned IND_1       = 11,
  parameter int unsigned CONTROL     = 3,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic               clk_IND,
  input  logic               rst_IND,
  input  logic [IND_1-1:0]   ind_1,
  input  logic [CONTROL-1:0] control,
  output logic [7:0]         seg,
  output logic [3:0]         an
);

  localparam int unsigned RCNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [IND_1-1:0]   ind_q;
  logic [CONTROL-1:0] ctl_q;
  logic               valid_q;
  logic               start_c;
  logic               conv_idle;
  logic               conv_done;
  logic [BCD_W-1:0]   bcd;
  logic [3:0][7:0]    fmt_c;
  logic [3:0][7:0]    dig_q, dig_d;
  logic [RCNT_W-1:0]  rcnt_q, rcnt_d;
  logic [1:0]         scan_q, scan_d;
  logic [7:0]         seg_q, seg_d;
  logic [3:0]         an_q, an_d;

  bin2bcd #(.BIN_W(IND_1)) u_bin2bcd (
    .clk_i   (clk_IND),
    .rst_i   (rst_IND),
    .start_i (start_c),
    .bin_i   (ind_q),
    .idle_o  (conv_idle),
    .done_o  (conv_done),
    .bcd_o   (bcd)
  );

  // Map the finished BCD value and latched status code onto four glyphs.
  always_comb begin
    logic [3:0] d3, d2, d1, d0;
    logic       z3, z32, z321;
    d3   = bcd[15:12];
    d2   = bcd[11:8];
    d1   = bcd[7:4];
    d0   = bcd[3:0];
    z3   = (d3 == 4'd0);
    z32  = z3 && (d2 == 4'd0);
    z321 = z32 && (d1 == 4'd0);
    fmt_c = {4{GLYPH_DASH}};
    case (ctl_q)
      CONTROL'(CODE_P), CONTROL'(CODE_M): begin
        fmt_c[3] = z3   ? GLYPH_BLANK : digit_glyph(d3);
        fmt_c[2] = z32  ? GLYPH_BLANK : digit_glyph(d2);
        fmt_c[1] = z321 ? GLYPH_BLANK : digit_glyph(d1);
        fmt_c[0] = digit_glyph(d0);
        if (ctl_q == CONTROL'(CODE_M)) fmt_c[3] = GLYPH_MINUS;
      end
      CONTROL'(CODE_D0): begin
        fmt_c = {GLYPH_E, GLYPH_R, GLYPH_R, GLYPH_BLANK};
      end
      CONTROL'(CODE_D): begin
        fmt_c[3] = z3 ? GLYPH_BLANK : digit_glyph(d3);
        fmt_c[2] = digit_glyph(d2) & DP_MASK;
        fmt_c[1] = digit_glyph(d1);
        fmt_c[0] = digit_glyph(d0);
      end
      default: begin
        fmt_c = {4{GLYPH_DASH}};
      end
    endcase
  end

  // seg/an are computed from the next digit and scan values so they always
  // match the registered digit and scan state on the same edge.
  always_comb begin
    start_c = conv_idle && (!valid_q || (ind_1 != ind_q) || (control != ctl_q));
    dig_d   = conv_done ? fmt_c : dig_q;
    rcnt_d  = rcnt_q + RCNT_W'(1);
    scan_d  = scan_q;
    if (rcnt_q == RCNT_W'(REFRESH_DIV - 1)) begin
      rcnt_d = '0;
      scan_d = scan_q + 2'd1;
    end
    seg_d = dig_d[scan_d];
    an_d  = ~(4'b0001 << scan_d);
  end

  always_ff @(posedge clk_IND) begin
    if (rst_IND) begin
      ind_q   <= '0;
      ctl_q   <= '0;
      valid_q <= 1'b0;
      dig_q   <= {4{GLYPH_BLANK}};
      rcnt_q  <= '0;
      scan_q  <= '0;
      seg_q   <= 8'hFF;
      an_q    <= 4'hF;
    end else begin
      if (start_c) begin
        ind_q   <= ind_1;
        ctl_q   <= control;
        valid_q <= 1'b1;
      end
      dig_q  <= dig_d;
      rcnt_q <= rcnt_d;
      scan_q <= scan_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_ind_driver.sv
// Directed bench for ind_driver with a short refresh period; expected display
// frames are queued when inputs are driven and checked when the glyphs appear.
module tb_ind_driver;

  localparam int unsigned W  = 11;
  localparam int unsigned CW = 3;
  localparam int unsigned RD = 4;

  typedef logic [3:0][7:0] frame_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  ind;
  logic [CW-1:0] ctl;
  logic [7:0]    seg;
  logic [3:0]    an;

  int     n_chk  = 0;
  int     n_fail = 0;
  frame_t prev;
  frame_t exp_q[$];
  string  tag_q[$];

  always #5 clk = ~clk;

  ind_driver #(.IND_1(W), .CONTROL(CW), .REFRESH_DIV(RD)) dut (
    .clk_IND (clk),
    .rst_IND (rst),
    .ind_1   (ind),
    .control (ctl),
    .seg     (seg),
    .an      (an)
  );

  function automatic logic [7:0] chr(input byte c);
    case (c)
      "0": return 8'hC0;
      "1": return 8'hF9;
      "2": return 8'hA4;
      "3": return 8'hB0;
      "4": return 8'h99;
      "5": return 8'h92;
      "6": return 8'h82;
      "7": return 8'hF8;
      "8": return 8'h80;
      "9": return 8'h90;
      "-": return 8'hBF;
      "E": return 8'h86;
      "r": return 8'hAF;
      default: return 8'hFF;
    endcase
  endfunction

  // Leftmost character is digit 3; dp >= 0 lights that digit's decimal point.
  function automatic frame_t mk(input string s, input int dp);
    frame_t f;
    f = {4{8'hFF}};
    for (int i = 0; i < 4; i++) f[3-i] = chr(s[i]);
    if (dp >= 0) f[dp][7] = 1'b0;
    return f;
  endfunction

  function automatic int an_idx(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_seg(input string tag, input frame_t f);
    int idx;
    idx = an_idx(an);
    n_chk++;
    assert (idx >= 0) else begin
      n_fail++;
      $error("FAIL %s_an_onehot: observed %b expected one low bit", tag, an);
    end
    if (idx >= 0) chk(tag, 32'(seg), 32'(f[idx]));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int v, input int c, input string s, input int dp);
    ind = W'(v);
    ctl = CW'(c);
    exp_q.push_back(mk(s, dp));
    tag_q.push_back(s);
  endtask

  task automatic pop_check();
    frame_t cur;
    string  t;
    cur = exp_q.pop_front();
    t   = tag_q.pop_front();
    check_seg({"new '", t, "'"}, cur);
    prev = cur;
  endtask

  // Walk all four scan slots and check every displayed digit.
  task automatic frame_check();
    for (int n = 0; n < 16; n++) begin
      tick();
      check_seg("scan", prev);
    end
  endtask

  task automatic apply(input int v, input int c, input string s, input int dp);
    drive(v, c, s, dp);
    for (int n = 1; n <= 14; n++) begin
      tick();
      if (n == 13) check_seg("stale", prev);
      if (n == 14) pop_check();
    end
    frame_check();
  endtask

  // Release reset; checks the scan order and the first conversion latency.
  task automatic release_rst(input string s, input int dp);
    logic [3:0] exp_an;
    prev = mk("    ", -1);
    exp_q.push_back(mk(s, dp));
    tag_q.push_back(s);
    rst = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      tick();
      exp_an = ~(4'b0001 << ((n / 4) % 4));
      chk("an_seq", 32'(an), 32'(exp_an));
      if (n == 13) check_seg("post_rst_blank", prev);
      if (n == 14) pop_check();
    end
    frame_check();
  endtask

  initial begin
    rst = 1'b1;
    ind = '0;
    ctl = '0;
    repeat (3) tick();
    chk("rst_seg", 32'(seg), 32'h0000_00FF);
    chk("rst_an", 32'(an), 32'h0000_000F);

    release_rst("   0", -1);

    apply(225,  0, " 225", -1);
    apply(7,    1, "-  7", -1);
    apply(150,  4, " 150",  2);
    apply(1500, 4, "1500",  2);
    apply(5,    4, " 005",  2);
    apply(2047, 0, "2047", -1);
    apply(123,  2, "Err ", -1);
    apply(9,    2, "Err ", -1);
    apply(55,   3, "----", -1);
    apply(0,    1, "-  0", -1);

    // Input change three cycles into SHIFT: old result first, then re-conversion.
    drive(100, 0, " 100", -1);
    for (int n = 1; n <= 28; n++) begin
      tick();
      if (n == 5) drive(999, 0, " 999", -1);
      if (n == 13 || n == 27) check_seg("stale", prev);
      if (n == 14 || n == 28) pop_check();
    end
    frame_check();

    // Reset in the middle of SHIFT aborts the conversion.
    ind = W'(321);
    ctl = '0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    chk("midrst_seg", 32'(seg), 32'h0000_00FF);
    chk("midrst_an", 32'(an), 32'h0000_000F);
    tick();
    release_rst(" 321", -1);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
